// File: rtl/pulse_train_gen_if.sv
// pulse_train_gen_if: control/status bundle for the pulse-train generator.
// The master side (stimulus/control block) drives the request fields and
// observes the waveform and strobes; the slave side is the generator itself.
interface pulse_train_gen_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             start_i;
  logic [CNT_W-1:0] high_len_i;
  logic [CNT_W-1:0] low_len_i;
  logic [CNT_W-1:0] count_i;
  logic             abort_i;
  logic             wave_o;
  logic             rise_o;
  logic             fall_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i,
    output high_len_i,
    output low_len_i,
    output count_i,
    output abort_i,
    input  wave_o,
    input  rise_o,
    input  fall_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  high_len_i,
    input  low_len_i,
    input  count_i,
    input  abort_i,
    output wave_o,
    output rise_o,
    output fall_o,
    output busy_o,
    output done_o
  );

endinterface

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable square-wave generator. On an accepted start it
// emits count periods of high_len high cycles followed by low_len low cycles,
// flagging every edge with a one-cycle strobe and the normal end with done.
// All outputs are registered and derived from the next state, so the strobes
// line up with the first cycle of each phase.
// Optional build macro PULSE_GEN_CONT_EN: a start with count 0 runs a
// continuous train until aborted (no done pulse). Without it such a start is
// ignored.
module pulse_train_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  pulse_train_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntZero = '0;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic             wave_q, wave_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PULSE_GEN_CONT_EN
  logic             cont_q, cont_d;
`endif

  // Effective lengths of the request: zero is promoted to one cycle.
  logic [CNT_W-1:0] req_high_len;
  logic [CNT_W-1:0] req_low_len;
  logic             phase_last;

  always_comb begin
    req_high_len = (bus.high_len_i == CntZero) ? CntOne : bus.high_len_i;
    req_low_len  = (bus.low_len_i  == CntZero) ? CntOne : bus.low_len_i;
    // Lengths are never below one, so <= also guards against a stray zero.
    phase_last   = (phase_q <= CntOne);
  end

  // Next-state logic: phase/period counting, start acceptance and abort.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    period_d   = period_q;
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    done_d     = 1'b0;
`ifdef PULSE_GEN_CONT_EN
    cont_d     = cont_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start_i && (bus.count_i != CntZero)) begin
          state_d    = StHigh;
          high_len_d = req_high_len;
          low_len_d  = req_low_len;
          phase_d    = req_high_len;
          period_d   = bus.count_i;
`ifdef PULSE_GEN_CONT_EN
          cont_d     = 1'b0;
`endif
        end
`ifdef PULSE_GEN_CONT_EN
        else if (bus.start_i) begin
          state_d    = StHigh;
          high_len_d = req_high_len;
          low_len_d  = req_low_len;
          phase_d    = req_high_len;
          period_d   = CntZero;
          cont_d     = 1'b1;
        end
`endif
      end

      StHigh: begin
        if (bus.abort_i) begin
          state_d  = StIdle;
          phase_d  = CntZero;
          period_d = CntZero;
        end else if (phase_last) begin
          state_d = StLow;
          phase_d = low_len_q;
        end else begin
          phase_d = phase_q - CntOne;
        end
      end

      StLow: begin
        if (bus.abort_i) begin
          state_d  = StIdle;
          phase_d  = CntZero;
          period_d = CntZero;
        end else if (phase_last) begin
`ifdef PULSE_GEN_CONT_EN
          if (cont_q) begin
            // Continuous train: period counter is left untouched.
            state_d = StHigh;
            phase_d = high_len_q;
          end else
`endif
          if (period_q <= CntOne) begin
            state_d  = StIdle;
            phase_d  = CntZero;
            period_d = CntZero;
            done_d   = 1'b1;
          end else begin
            state_d  = StHigh;
            phase_d  = high_len_q;
            period_d = period_q - CntOne;
          end
        end else begin
          phase_d = phase_q - CntOne;
        end
      end

      default: begin
        state_d  = StIdle;
        phase_d  = CntZero;
        period_d = CntZero;
      end
    endcase
  end

  // Registered outputs follow the next state; edges are strobed on entry.
  always_comb begin
    wave_d = (state_d == StHigh);
    busy_d = (state_d != StIdle);
    rise_d = (state_d == StHigh) && (state_q != StHigh);
    // Covers both the normal HIGH->LOW edge and an abort out of HIGH.
    fall_d = (state_q == StHigh) && (state_d != StHigh);
  end

  // State, counters, latched fields and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      period_q   <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      wave_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PULSE_GEN_CONT_EN
      cont_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      period_q   <= period_d;
      high_len_q <= high_len_d;
      low_len_q  <= low_len_d;
      wave_q     <= wave_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PULSE_GEN_CONT_EN
      cont_q     <= cont_d;
`endif
    end
  end

  assign bus.wave_o = wave_q;
  assign bus.rise_o = rise_q;
  assign bus.fall_o = fall_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

endmodule
